// File: rtl/halt_ctrl.sv
// Halt/stall controller: stalls the PC for input, output, halt and stop instructions.
// Optional macro HALT_TIMEOUT_EN adds an auto-resume counter in HALT.
module halt_ctrl #(
    parameter int unsigned HALT_TIMEOUT = 50000000,
    parameter int unsigned CNT_W        = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_valid,
    input  logic       haltOp,
    input  logic       sleep,
    input  logic       inop,
    input  logic       outop,
    input  logic       confirm,
    input  logic       resume,
    input  logic       out_ack,
    output logic       pc_en,
    output logic       in_latch,
    output logic       out_req,
    output logic       halted,
    output logic       stopped,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        WAIT_IN  = 3'd1,
        WAIT_OUT = 3'd2,
        HALT     = 3'd3,
        STOP     = 3'd4
    } state_t;

    if (64'(HALT_TIMEOUT) >= (64'd1 << CNT_W)) begin : g_bad_cnt_w
        $error("halt_ctrl: CNT_W too narrow for HALT_TIMEOUT");
    end

    state_t     r_state;
    state_t     w_next;
    logic       w_pc_en;
    logic       w_in_latch;
    logic       w_tmo;
    logic       w_req;

    // Index 0 = confirm, 1 = resume
    logic [1:0] w_pin;
    logic [1:0] r_sync1;
    logic [1:0] r_sync2;
    logic [1:0] r_prev;
    logic [1:0] r_arm;
    logic [1:0] r_live;
    logic [1:0] w_pulse;
    logic       w_conf_p;
    logic       w_res_p;

    assign w_pin = {resume, confirm};

    // Synchronizer plus edge detector; r_arm requires a low level seen after reset
    // so a button held through reset cannot fire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
            r_arm   <= '0;
            r_live  <= '0;
        end else begin
            r_sync1 <= w_pin;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_live  <= {r_live[0], 1'b1};
            r_arm   <= r_arm | ({2{r_live[1]}} & ~r_sync2);
        end
    end

    assign w_pulse  = r_arm & r_sync2 & ~r_prev;
    assign w_conf_p = w_pulse[0];
    assign w_res_p  = w_pulse[1];

`ifdef HALT_TIMEOUT_EN
    logic [CNT_W-1:0] r_cnt;

    // Zero outside HALT, so it starts at 0 on every HALT entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state != HALT) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_tmo = (r_state == HALT) && (r_cnt == CNT_W'(HALT_TIMEOUT - 1));
`else
    assign w_tmo = 1'b0;
`endif

    assign w_req = instr_valid && (sleep || haltOp || inop || outop);

    always_comb begin
        w_next     = r_state;
        w_pc_en    = 1'b0;
        w_in_latch = 1'b0;
        case (r_state)
            RUN: begin
                w_pc_en = !w_req;
                if (instr_valid) begin
                    if (sleep)       w_next = STOP;
                    else if (haltOp) w_next = HALT;
                    else if (inop)   w_next = WAIT_IN;
                    else if (outop)  w_next = WAIT_OUT;
                end
            end
            WAIT_IN: begin
                if (w_conf_p) begin
                    w_in_latch = 1'b1;
                    w_pc_en    = 1'b1;
                    w_next     = RUN;
                end
            end
            WAIT_OUT: begin
                if (out_ack) begin
                    w_pc_en = 1'b1;
                    w_next  = RUN;
                end
            end
            HALT: begin
                if (w_conf_p || w_res_p || w_tmo) begin
                    w_pc_en = 1'b1;
                    w_next  = RUN;
                end
            end
            STOP:    w_next = STOP;
            default: w_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next;
        end
    end

    assign pc_en    = w_pc_en & rst_n;
    assign in_latch = w_in_latch & rst_n;
    assign out_req  = (r_state == WAIT_OUT);
    assign halted   = (r_state == HALT);
    assign stopped  = (r_state == STOP);
    assign state    = r_state;

endmodule

// File: tb/tb_halt_ctrl.sv
// Directed self-checking bench for halt_ctrl (HALT_TIMEOUT=8, CNT_W=4).
module tb_halt_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       instr_valid, haltOp, sleep, inop, outop;
    logic       confirm, resume, out_ack;
    logic       pc_en, in_latch, out_req, halted, stopped;
    logic [2:0] state;

    int n_vec = 0;
    int n_err = 0;

    halt_ctrl #(.HALT_TIMEOUT(8), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .haltOp(haltOp),
        .sleep(sleep), .inop(inop), .outop(outop), .confirm(confirm),
        .resume(resume), .out_ack(out_ack), .pc_en(pc_en), .in_latch(in_latch),
        .out_req(out_req), .halted(halted), .stopped(stopped), .state(state)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0; instr_valid = 0; haltOp = 0; sleep = 0; inop = 0; outop = 0;
        confirm = 0; resume = 0; out_ack = 0;
        repeat (3) @(negedge clk);
        #1;
        n_vec++; if (state !== 3'd0) begin n_err++; $display("FAIL reset_state got %0d exp 0", state); end
        n_vec++; if (pc_en !== 1'b0) begin n_err++; $display("FAIL reset_pc_en got %b exp 0", pc_en); end
        n_vec++; if ({in_latch, out_req, halted, stopped} !== 4'b0) begin
            n_err++; $display("FAIL reset_outs got %b exp 0000", {in_latch, out_req, halted, stopped}); end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        n_vec++; if (pc_en !== 1'b1) begin n_err++; $display("FAIL run_idle_pc_en got %b exp 1", pc_en); end
    endtask

    task automatic test_wait_in();
        @(negedge clk); instr_valid = 1; inop = 1; #1;
        n_vec++; if (pc_en !== 1'b0) begin n_err++; $display("FAIL in_stall_pc_en got %b exp 0", pc_en); end
        @(negedge clk); instr_valid = 0; inop = 0; #1;
        n_vec++; if (state !== 3'd1) begin n_err++; $display("FAIL in_state got %0d exp 1", state); end
        confirm = 1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk); #1;
            n_vec++; if (in_latch !== (c == 2)) begin
                n_err++; $display("FAIL in_latch c=%0d got %b exp %b", c, in_latch, (c == 2)); end
            n_vec++; if (pc_en !== (c >= 2)) begin
                n_err++; $display("FAIL in_pc_en c=%0d got %b exp %b", c, pc_en, (c >= 2)); end
            n_vec++; if (state !== ((c >= 3) ? 3'd0 : 3'd1)) begin
                n_err++; $display("FAIL in_state c=%0d got %0d", c, state); end
        end
        confirm = 0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_wait_out();
        @(negedge clk); instr_valid = 1; outop = 1; #1;
        n_vec++; if ({pc_en, out_req} !== 2'b00) begin
            n_err++; $display("FAIL out_req_cycle got %b exp 00", {pc_en, out_req}); end
        @(negedge clk); instr_valid = 0; outop = 0; confirm = 1; #1;
        for (int c = 1; c <= 4; c++) begin
            n_vec++; if ({state, out_req, pc_en} !== {3'd2, 2'b10}) begin
                n_err++; $display("FAIL out_wait c=%0d got %b exp 01010", c, {state, out_req, pc_en}); end
            @(negedge clk); #1;
        end
        out_ack = 1; confirm = 0; #1;
        n_vec++; if ({out_req, pc_en} !== 2'b11) begin
            n_err++; $display("FAIL out_ack_cycle got %b exp 11", {out_req, pc_en}); end
        @(negedge clk); out_ack = 0; #1;
        n_vec++; if ({state, out_req} !== {3'd0, 1'b0}) begin
            n_err++; $display("FAIL out_done got %b exp 0000", {state, out_req}); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_stop();
        @(negedge clk); instr_valid = 1; sleep = 1; haltOp = 1; #1;
        n_vec++; if (pc_en !== 1'b0) begin n_err++; $display("FAIL stop_req_pc_en got %b exp 0", pc_en); end
        @(negedge clk); sleep = 0; haltOp = 0; inop = 1; confirm = 1; resume = 1; out_ack = 1;
        for (int c = 1; c <= 8; c++) begin
            #1;
            n_vec++; if ({state, stopped, halted, pc_en} !== {3'd4, 3'b100}) begin
                n_err++; $display("FAIL stop_hold c=%0d got %b exp 100100", c, {state, stopped, halted, pc_en}); end
            @(negedge clk);
            confirm = c[0]; resume = ~c[0]; out_ack = c[1];
        end
        instr_valid = 0; inop = 0; confirm = 0; resume = 0; out_ack = 0;
        repeat (3) @(negedge clk);
        #2 rst_n = 0; #1;
        n_vec++; if ({state, stopped} !== 4'b0) begin
            n_err++; $display("FAIL stop_reset got %b exp 0000", {state, stopped}); end
        @(negedge clk); rst_n = 1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_halt_both();
        @(negedge clk); instr_valid = 1; haltOp = 1; #1;
        n_vec++; if (pc_en !== 1'b0) begin n_err++; $display("FAIL halt_req_pc_en got %b exp 0", pc_en); end
        @(negedge clk); instr_valid = 0; haltOp = 0; confirm = 1; resume = 1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk); #1;
            n_vec++; if (pc_en !== (c >= 2)) begin
                n_err++; $display("FAIL both_pc_en c=%0d got %b exp %b", c, pc_en, (c >= 2)); end
            n_vec++; if (halted !== (c < 3)) begin
                n_err++; $display("FAIL both_halted c=%0d got %b exp %b", c, halted, (c < 3)); end
        end
        confirm = 0; resume = 0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_timeout();
        @(negedge clk); instr_valid = 1; haltOp = 1;
        @(negedge clk); instr_valid = 0; haltOp = 0;
`ifdef HALT_TIMEOUT_EN
        for (int c = 1; c <= 11; c++) begin
            #1;
            n_vec++; if (halted !== (c <= 8)) begin
                n_err++; $display("FAIL tmo_halted c=%0d got %b exp %b", c, halted, (c <= 8)); end
            n_vec++; if (pc_en !== (c >= 8)) begin
                n_err++; $display("FAIL tmo_pc_en c=%0d got %b exp %b", c, pc_en, (c >= 8)); end
            @(negedge clk);
        end
`else
        repeat (100) @(negedge clk);
        #1;
        n_vec++; if ({halted, pc_en, state} !== {2'b10, 3'd3}) begin
            n_err++; $display("FAIL no_tmo_still_halted got %b exp 10011", {halted, pc_en, state}); end
        resume = 1;
        repeat (4) @(negedge clk);
        #1;
        n_vec++; if (state !== 3'd0) begin n_err++; $display("FAIL no_tmo_resume got %0d exp 0", state); end
        resume = 0;
        repeat (4) @(negedge clk);
`endif
    endtask

    task automatic test_reset_in_wait_out();
        @(negedge clk); instr_valid = 1; outop = 1;
        @(negedge clk); instr_valid = 0; outop = 0;
        @(negedge clk); #1;
        n_vec++; if (out_req !== 1'b1) begin n_err++; $display("FAIL rwo_out_req got %b exp 1", out_req); end
        #2 rst_n = 0; out_ack = 1; #1;
        n_vec++; if ({out_req, pc_en, state} !== 5'b0) begin
            n_err++; $display("FAIL rwo_async got %b exp 00000", {out_req, pc_en, state}); end
        @(negedge clk); #1;
        n_vec++; if (pc_en !== 1'b0) begin n_err++; $display("FAIL rwo_pc_en got %b exp 0", pc_en); end
        out_ack = 0; rst_n = 1;
        @(negedge clk); #1;
        n_vec++; if ({state, out_req} !== 4'b0) begin
            n_err++; $display("FAIL rwo_after got %b exp 0000", {state, out_req}); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_held_button();
        rst_n = 0; confirm = 1;
        @(negedge clk); rst_n = 1;
        @(negedge clk); instr_valid = 1; inop = 1;
        @(negedge clk); instr_valid = 0; inop = 0;
        for (int c = 1; c <= 6; c++) begin
            #1;
            n_vec++; if ({state, in_latch} !== {3'd1, 1'b0}) begin
                n_err++; $display("FAIL held_no_pulse c=%0d got %b exp 0010", c, {state, in_latch}); end
            @(negedge clk);
        end
        confirm = 0;
        repeat (3) @(negedge clk);
        confirm = 1;
        repeat (2) @(negedge clk);
        #1;
        n_vec++; if (in_latch !== 1'b1) begin n_err++; $display("FAIL held_then_press got %b exp 1", in_latch); end
        confirm = 0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_wait_in();
        test_wait_out();
        test_stop();
        test_halt_both();
        test_timeout();
        test_reset_in_wait_out();
        test_held_button();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/halt_ctrl.md
HALT_CTRL -- requirements
Module: halt_ctrl

Interface
REQ-001 SHALL have parameter HALT_TIMEOUT, default 50000000, meaning the number of clk cycles in HALT before auto-resume (used only with HALT_TIMEOUT_EN).
REQ-002 SHALL have parameter CNT_W, default 26, meaning the halt-counter width; it SHALL satisfy 2^CNT_W > HALT_TIMEOUT.
REQ-003 SHALL have ports, clock and reset first:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  decoded control bits below are valid this cycle.
- haltOp  in  1  halt request from the control unit.
- sleep  in  1  STOP request from the control unit.
- inop  in  1  input-instruction request from the control unit.
- outop  in  1  output-instruction request from the control unit.
- confirm  in  1  asynchronous user button, active-high.
- resume  in  1  asynchronous external resume line, active-high.
- out_ack  in  1  display accepted the output value, synchronous to clk.
- pc_en  out  1  PC may advance this cycle.
- in_latch  out  1  capture the input-switch value into the register file this cycle.
- out_req  out  1  output value is valid for the display.
- halted  out  1  FSM is in HALT.
- stopped  out  1  FSM is in STOP.
- state  out  3  FSM state encoding, for debug.

Function
REQ-004 SHALL pass confirm and resume each through a 2-flop synchronizer and then a rising-edge detector, producing single-cycle pulses conf_p and res_p; the pulses SHALL lag the pin edge by 2-3 cycles.
REQ-005 SHALL implement the states RUN=0, WAIT_IN=1, WAIT_OUT=2, HALT=3 and STOP=4; encodings 5-7 SHALL go to RUN on the next edge.
REQ-006 In RUN with instr_valid=1, the next state SHALL be chosen by priority sleep > haltOp > inop > outop: STOP, HALT, WAIT_IN or WAIT_OUT respectively; with none set, the FSM stays in RUN.
REQ-007 In RUN, pc_en SHALL be combinational: 1 unless instr_valid=1 and any of sleep, haltOp, inop or outop is 1.
REQ-008 In WAIT_IN, on conf_p: in_latch=1 and pc_en=1 for exactly that cycle, and next state RUN; otherwise pc_en=0 and in_latch=0.
REQ-009 In WAIT_OUT, out_req SHALL be 1; on out_ack=1: pc_en=1 for that cycle and next state RUN; out_req SHALL fall on the following edge.
REQ-010 out_ack outside WAIT_OUT SHALL be ignored; conf_p outside WAIT_IN and HALT SHALL be ignored and SHALL NOT be remembered.
REQ-011 In HALT, halted=1; conf_p or res_p (either, or both in the same cycle) SHALL give pc_en=1 for that cycle and next state RUN.
REQ-012 In STOP, stopped=1 and pc_en=0; only reset SHALL leave STOP, and all inputs SHALL be ignored.
REQ-013 In WAIT_IN, WAIT_OUT and HALT, the control-unit inputs SHALL be ignored.
REQ-014 The completion cycle's pc_en pulse SHALL advance the PC past the stalled instruction, so it is not re-decoded.
REQ-015 in_latch and pc_en SHALL be combinational from the state and the qualified events; out_req, halted, stopped and state SHALL be registered or decoded directly from the state register.
REQ-016 The FSM SHALL advance at most one state per cycle; latency from a request to the stall (pc_en=0) SHALL be 0 cycles.

Reset
REQ-017 While rst_n=0: state=RUN, pc_en=0 (gated by rst_n), in_latch=0, out_req=0, halted=0, stopped=0, synchronizers and halt counter cleared.
REQ-018 Reset asserted mid-wait (WAIT_IN, WAIT_OUT, HALT or STOP) SHALL abort the wait with no in_latch pulse, and out_req SHALL drop asynchronously.
REQ-019 After release, the first edge-detected pulse SHALL require a 0->1 transition seen after reset; a button held through reset SHALL NOT generate conf_p.

Configuration
REQ-020 Macro HALT_TIMEOUT_EN, when defined, SHALL add a CNT_W-bit counter:
- cleared on HALT entry and incremented each cycle in HALT;
- at the count HALT_TIMEOUT-1 it forces the resume behaviour (pc_en=1, next state RUN);
- an earlier conf_p or res_p resumes as normal and clears the counter.
REQ-021 Without HALT_TIMEOUT_EN, no counter SHALL be built and HALT SHALL be left only by conf_p, res_p or reset.

Verification
REQ-022 Verification SHALL cover these directed scenarios:
- instr_valid=1, inop=1 at cycle 10 -> pc_en=0 at cycle 10; state=1 from cycle 11; confirm pin rising at cycle 20 -> in_latch=1 and pc_en=1 for one cycle within cycles 22-23; state=0 on the next edge.
- outop=1 -> out_req=1 from the next cycle; out_ack=1 held 1 cycle at cycle +5 -> pc_en=1 in that cycle; out_req=0 one cycle later.
- sleep=1 and haltOp=1 together -> state=4 and stopped=1; confirm, resume and out_ack pulses -> no change; rst_n low -> state=0, stopped=0.
- HALT_TIMEOUT_EN defined, HALT_TIMEOUT=8, haltOp=1 -> halted=1 for exactly 8 cycles, then pc_en=1 for one cycle and state=0; same test without the macro -> still halted after 100 cycles.
- In HALT, confirm and resume rising in the same cycle -> a single pc_en pulse and a single return to RUN; rst_n pulsed low during WAIT_OUT -> out_req=0 immediately, no pc_en pulse.
